// File: rtl/ins_fetch.sv
// Instruction fetch initiator: drives ins_mem, tracks the PC and hands
// each fetched word to the decoder over a valid/ready handshake.
module ins_fetch #(
   parameter int                    ADDR_WIDTH  = 8,
   parameter int                    INS_WIDTH   = 8,
   parameter logic [ADDR_WIDTH-1:0] START_ADDR  = '0,
   parameter logic [INS_WIDTH-1:0]  HALT_OPCODE = 8'hFF
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   output logic [ADDR_WIDTH-1:0] PC_address,
   output logic                  rEn,
   input  logic [INS_WIDTH-1:0]  instruction,
   output logic [INS_WIDTH-1:0]  ins_out,
   output logic [ADDR_WIDTH-1:0] pc_out,
   output logic                  ins_valid,
   input  logic                  ins_ready,
   input  logic                  jump_en,
   input  logic [ADDR_WIDTH-1:0] jump_addr,
   output logic                  busy,
   output logic                  halted
);

   typedef enum logic [2:0] {
      IDLE,
      REQ,
      WAIT,
      HOLD,
      HALTED
   } state_t;

   state_t                state, state_n;
   logic [ADDR_WIDTH-1:0] pc, pc_n;
   logic                  accept;

   assign busy   = (state == REQ) || (state == WAIT) || (state == HOLD);
   assign halted = (state == HALTED);
   assign accept = (state == HOLD) && ins_valid && ins_ready;

   always_comb begin
      state_n = state;
      pc_n    = pc;
      case (state)
         IDLE, HALTED: begin
            if (start) begin
               pc_n    = START_ADDR;
               state_n = REQ;
            end
         end
         REQ:  state_n = WAIT;
         WAIT: state_n = HOLD;
         HOLD: begin
            if (accept) begin
               if (ins_out == HALT_OPCODE) begin
                  state_n = HALTED;
               end else begin
                  pc_n    = pc + 1'b1;
                  state_n = REQ;
               end
            end
         end
         default: state_n = IDLE;
      endcase
      // A redirect overrides sequential advance and halt alike
      if (jump_en && busy) begin
         pc_n    = jump_addr;
         state_n = REQ;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         pc         <= '0;
         PC_address <= '0;
         rEn        <= 1'b0;
         ins_out    <= '0;
         pc_out     <= '0;
         ins_valid  <= 1'b0;
      end else begin
         state <= state_n;
         pc    <= pc_n;
         rEn   <= (state_n == REQ);
         if (state_n == REQ) begin
            PC_address <= pc_n;
         end
         if (state == WAIT && !jump_en) begin
            ins_out   <= instruction;
            pc_out    <= pc;
            ins_valid <= 1'b1;
         end else if (state == HOLD && (accept || jump_en)) begin
            ins_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_ins_fetch.sv
// Directed bench for ins_fetch with a registered ins_mem model.
module tb_ins_fetch;

   logic       clk = 1'b0;
   logic       rst;
   logic       start;
   logic [7:0] PC_address;
   logic       rEn;
   logic [7:0] instruction;
   logic [7:0] ins_out;
   logic [7:0] pc_out;
   logic       ins_valid;
   logic       ins_ready;
   logic       jump_en;
   logic [7:0] jump_addr;
   logic       busy;
   logic       halted;

   logic [7:0] mem [256];
   int         n_chk  = 0;
   int         n_pass = 0;
   int         ren_cnt;

   ins_fetch dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .PC_address (PC_address),
      .rEn        (rEn),
      .instruction(instruction),
      .ins_out    (ins_out),
      .pc_out     (pc_out),
      .ins_valid  (ins_valid),
      .ins_ready  (ins_ready),
      .jump_en    (jump_en),
      .jump_addr  (jump_addr),
      .busy       (busy),
      .halted     (halted)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (rEn) instruction <= mem[PC_address];
   end

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      for (int i = 0; i < 256; i++) mem[i] = 8'h00;
      mem[0] = 8'h11; mem[1] = 8'h22; mem[2] = 8'h33; mem[3] = 8'h44;
      mem[8'h0A] = 8'h5A; mem[8'h10] = 8'hFF;
      mem[8'h20] = 8'h77; mem[8'hFF] = 8'h42;
      instruction = 8'h00;
      rst = 1'b1; start = 1'b0; ins_ready = 1'b0;
      jump_en = 1'b0; jump_addr = 8'h00;

      // reset and idle
      tick(); tick();
      rst = 1'b0;
      ren_cnt = 0;
      for (int i = 0; i < 5; i++) begin
         tick();
         if (rEn) ren_cnt++;
      end
      chk("idle_ren_pulses", ren_cnt, 0);
      chk("rst_pc_address", PC_address, 0);
      chk("rst_ins_out", ins_out, 0);
      chk("rst_pc_out", pc_out, 0);
      chk("rst_valid", ins_valid, 0);
      chk("rst_busy", busy, 0);
      chk("rst_halted", halted, 0);

      // sequential fetch
      ins_ready = 1'b1;
      start = 1'b1;
      tick();
      start = 1'b0;
      chk("seq_first_ren", rEn, 1);
      chk("seq_first_addr", PC_address, 0);
      for (int k = 0; k < 4; k++) begin
         if (k > 0) begin
            tick();
            chk("seq_ren", rEn, 1);
            chk("seq_addr", PC_address, k);
            chk("seq_valid_low", ins_valid, 0);
         end
         tick();
         chk("seq_wait_ren", rEn, 0);
         tick();
         chk("seq_valid", ins_valid, 1);
         chk("seq_ins", ins_out, {24'h0, mem[k]});
         chk("seq_pc", pc_out, k);
      end

      // backpressure
      rst = 1'b1; tick(); rst = 1'b0;
      start = 1'b1; tick(); start = 1'b0;
      tick(); tick();
      chk("bp_ins0", ins_out, 8'h11);
      tick();
      ins_ready = 1'b0;
      tick(); tick();
      ren_cnt = 0;
      for (int i = 0; i < 6; i++) begin
         tick();
         if (rEn) ren_cnt++;
      end
      chk("bp_ren_pulses", ren_cnt, 0);
      chk("bp_ins", ins_out, 8'h22);
      chk("bp_pc", pc_out, 1);
      chk("bp_valid", ins_valid, 1);
      ins_ready = 1'b1;
      tick();
      chk("bp_next_ren", rEn, 1);
      chk("bp_next_addr", PC_address, 2);
      tick(); tick();
      ins_ready = 1'b0;
      chk("bp_next_ins", ins_out, 8'h33);

      // jump during WAIT
      ins_ready = 1'b1;
      tick(); tick();
      jump_en = 1'b1; jump_addr = 8'h0A;
      tick();
      jump_en = 1'b0;
      chk("jw_ren", rEn, 1);
      chk("jw_addr", PC_address, 8'h0A);
      chk("jw_valid_low", ins_valid, 0);
      tick();
      chk("jw_no_present", ins_valid, 0);
      tick();
      chk("jw_ins", ins_out, 8'h5A);
      chk("jw_pc", pc_out, 8'h0A);

      // jump in HOLD with accept
      jump_en = 1'b1; jump_addr = 8'h10;
      tick();
      jump_en = 1'b0;
      chk("jh_addr", PC_address, 8'h10);
      chk("jh_valid_low", ins_valid, 0);
      tick(); tick();
      chk("jh_ins", ins_out, 8'hFF);
      chk("jh_pc", pc_out, 8'h10);
      // accepting the halt word while jumping still redirects
      jump_en = 1'b1; jump_addr = 8'h20;
      tick();
      jump_en = 1'b0;
      chk("jh_over_halt", halted, 0);
      chk("jh2_ren", rEn, 1);
      chk("jh2_addr", PC_address, 8'h20);
      tick(); tick();
      chk("jh2_ins", ins_out, 8'h77);

      // halt and restart
      mem[2] = 8'hFF;
      rst = 1'b1; tick(); rst = 1'b0;
      start = 1'b1; tick(); start = 1'b0;
      tick(); tick();
      tick(); tick(); tick();
      tick(); tick(); tick();
      chk("halt_ins", ins_out, 8'hFF);
      chk("halt_pc", pc_out, 2);
      tick();
      chk("halt_flag", halted, 1);
      chk("halt_valid", ins_valid, 0);
      chk("halt_busy", busy, 0);
      ren_cnt = 0;
      for (int i = 0; i < 10; i++) begin
         tick();
         if (rEn) ren_cnt++;
      end
      chk("halt_ren_pulses", ren_cnt, 0);
      start = 1'b1; tick(); start = 1'b0;
      chk("restart_halted", halted, 0);
      chk("restart_ren", rEn, 1);
      chk("restart_addr", PC_address, 0);
      tick(); tick();
      chk("restart_ins", ins_out, 8'h11);

      // wrap
      jump_en = 1'b1; jump_addr = 8'hFF;
      tick();
      jump_en = 1'b0;
      tick(); tick();
      chk("wrap_ins", ins_out, 8'h42);
      chk("wrap_pc", pc_out, 8'hFF);
      tick();
      chk("wrap_addr", PC_address, 8'h00);
      chk("wrap_ren", rEn, 1);

      // reset during WAIT
      tick();
      rst = 1'b1; tick(); rst = 1'b0;
      tick(); tick();
      chk("rstw_valid", ins_valid, 0);
      chk("rstw_busy", busy, 0);
      chk("rstw_ren", rEn, 0);
      chk("rstw_ins", ins_out, 0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
